// File: rtl/f1_reaction_ctrl_pkg.sv
// f1_reaction_ctrl_pkg: shared state encoding and light constants for the start-light sequencer
package f1_reaction_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SEQ, HOLD, MEASURE, DONE} state_t;
  localparam logic [7:0] LIGHTS_ALL_ON = 8'hFF;
endpackage

// File: rtl/f1_reaction_ctrl_tick_gen.sv
// f1_reaction_ctrl_tick_gen: prescaler with sync clear and enable, one-cycle tick every DIV enabled cycles
module f1_reaction_ctrl_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = en_i && !clr_i && (cnt_q == W'(DIV - 1));
  // count 0..DIV-1 while enabled, restart from 0 on clear
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= tick_o ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/f1_reaction_ctrl.sv
// f1_reaction_ctrl: F1 start-light sequencer with random hold, reaction timing, false-start and timeout detection
module f1_reaction_ctrl
  import f1_reaction_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 28,
  parameter int MS_DIV   = 50,
  parameter int K_W      = 7,
  parameter int RT_W     = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            button_i,
  input  logic [K_W-1:0]  rand_k_i,
  output logic [7:0]      lights_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [RT_W-1:0] reaction_time_o,
  output logic            false_start_o,
  output logic            timeout_o
);
  localparam logic [RT_W-1:0] RT_MAX = '1;
  state_t          state_q, state_d;
  logic [7:0]      lights_q, lights_d;
  logic [K_W-1:0]  hold_q, hold_d;
  logic [RT_W-1:0] rt_q, rt_d, rtime_q, rtime_d;
  logic            fs_q, fs_d, to_q, to_d, start_q;
  logic            step_tick, ms_tick;
  wire start_rise = start_i && !start_q;
  wire in_run     = (state_q == SEQ) || (state_q == HOLD);
  f1_reaction_ctrl_tick_gen #(.DIV(TICK_DIV)) u_step (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(state_q == IDLE), .en_i(in_run), .tick_o(step_tick)
  );
  f1_reaction_ctrl_tick_gen #(.DIV(MS_DIV)) u_ms (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(state_q != MEASURE), .en_i(state_q == MEASURE), .tick_o(ms_tick)
  );
  assign lights_o        = lights_q;
  assign busy_o          = in_run || (state_q == MEASURE);
  assign result_valid_o  = state_q == DONE;
  assign reaction_time_o = rtime_q;
  assign false_start_o   = fs_q;
  assign timeout_o       = to_q;
  // game sequencing; a button press always takes priority over a tick in the same cycle
  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    hold_d   = hold_q;
    rt_d     = rt_q;
    rtime_d  = rtime_q;
    fs_d     = fs_q;
    to_d     = to_q;
    case (state_q)
      IDLE: if (start_rise) begin
        state_d  = SEQ;
        lights_d = 8'h01;
        rtime_d  = '0;
        fs_d     = 1'b0;
        to_d     = 1'b0;
      end
      SEQ, HOLD: if (button_i) begin
        state_d  = DONE;
        lights_d = '0;
        fs_d     = 1'b1;
      end else if (step_tick) begin
        if (state_q == SEQ && lights_q == LIGHTS_ALL_ON) begin
          state_d = HOLD;
          hold_d  = (rand_k_i == '0) ? K_W'(1) : rand_k_i;
        end else if (state_q == SEQ) lights_d = {lights_q[6:0], 1'b1};
        else if (hold_q == K_W'(1)) begin
          state_d  = MEASURE;
          lights_d = '0;
          rt_d     = '0;
        end else hold_d = hold_q - K_W'(1);
      end
      MEASURE: if (button_i) begin
        state_d = DONE;
        rtime_d = rt_q;
      end else if (ms_tick) begin
        rt_d = rt_q + RT_W'(1);
        if (rt_q == RT_MAX - RT_W'(1)) begin
          state_d = DONE;
          rtime_d = RT_MAX;
          to_d    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, all cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      lights_q <= '0;
      hold_q   <= '0;
      rt_q     <= '0;
      rtime_q  <= '0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      hold_q   <= hold_d;
      rt_q     <= rt_d;
      rtime_q  <= rtime_d;
      fs_q     <= fs_d;
      to_q     <= to_d;
      start_q  <= start_i;
    end
endmodule

// File: tb/tb_f1_reaction_ctrl.sv
// tb_f1_reaction_ctrl: vector table, corner sequences and random games against a timeline model
module tb_f1_reaction_ctrl;
  localparam int TICK_DIV = 4, MS_DIV = 2, K_W = 7, RT_W = 4;
  localparam int RT_MAX = (1 << RT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, button = 1'b0;
  logic [K_W-1:0] rand_k = '0;
  logic [7:0] lights;
  logic busy, rv, fs, to;
  logic [RT_W-1:0] rtime;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  f1_reaction_ctrl #(.TICK_DIV(TICK_DIV), .MS_DIV(MS_DIV), .K_W(K_W), .RT_W(RT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .button_i(button), .rand_k_i(rand_k),
    .lights_o(lights), .busy_o(busy), .result_valid_o(rv), .reaction_time_o(rtime),
    .false_start_o(fs), .timeout_o(to)
  );
  typedef struct {int k; int bt; int sp; bit hold; int done; int rt; int fs; int to;} vec_t;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic int outs();
    return int'({lights, busy, rv, rtime, fs, to});
  endfunction
  function automatic int meas_start(input int k);
    return 7 * TICK_DIV + TICK_DIV * (1 + ((k == 0) ? 1 : k));
  endfunction
  function automatic int done_at(input int k, input int bt);
    int tm = meas_start(k);
    return (bt >= 0 && bt < tm + RT_MAX * MS_DIV) ? bt + 1 : tm + RT_MAX * MS_DIV;
  endfunction
  // expected outputs t cycles after the first light came on, button held from cycle bt (-1: never)
  function automatic int model(input int k, input int bt, input int t);
    int tm = meas_start(k);
    int dn = done_at(k, bt);
    bit early = bt >= 0 && bt < tm;
    bit pressed = bt >= 0 && bt < tm + RT_MAX * MS_DIV;
    int r = early ? 0 : pressed ? (bt - tm) / MS_DIV : RT_MAX;
    int l = (t >= dn) ? 0 : (t < 7 * TICK_DIV) ? (1 << (t / TICK_DIV + 1)) - 1 : (t < tm) ? 255 : 0;
    int res = (t >= dn) ? ((r << 2) | (int'(early) << 1) | int'(!pressed)) : 0;
    return (l << 8) | (int'(t < dn) << 7) | (int'(t == dn) << 6) | res;
  endfunction
  task automatic launch(input int k);
    rand_k = K_W'(k);
    start = 1'b0;
    button = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic run_game(input int k, input int bt, input int sp, input bit hold,
                          output int odone, output int ort, output int ofs, output int oto);
    int dn = done_at(k, bt);
    odone = -1; ort = -1; ofs = -1; oto = -1;
    launch(k);
    for (int t = 0; t <= dn + 2; t++) begin
      chk($sformatf("cycle k=%0d bt=%0d t=%0d", k, bt, t), outs(), model(k, bt, t));
      if (rv && odone < 0) begin
        odone = t; ort = int'(rtime); ofs = int'(fs); oto = int'(to);
      end
      button = bt >= 0 && t >= bt;
      start = hold ? (sp >= 0 && t >= sp) : (t == sp);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    button = 1'b0;
  endtask
  task automatic reset_mid(input int k, input int n);
    launch(k);
    repeat (n) @(posedge clk);
    #1 chk($sformatf("pre-reset k=%0d n=%0d", k, n), outs(), model(k, -1, n));
    #2 rst_n = 1'b0;
    #1 chk("async reset outs", outs(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post-reset idle", outs(), 0);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    vec_t v[7];
    int d, r, f, o, k, bt, sp, mode, tm;
    v[0] = '{k:3, bt:50, sp:-1, hold:0, done:51, rt:3,  fs:0, to:0};
    v[1] = '{k:3, bt:9,  sp:-1, hold:0, done:10, rt:0,  fs:1, to:0};
    v[2] = '{k:2, bt:-1, sp:-1, hold:0, done:70, rt:15, fs:0, to:1};
    v[3] = '{k:0, bt:36, sp:10, hold:0, done:37, rt:0,  fs:0, to:0};
    v[4] = '{k:1, bt:35, sp:-1, hold:0, done:36, rt:0,  fs:1, to:0};
    v[5] = '{k:5, bt:81, sp:60, hold:1, done:82, rt:14, fs:0, to:0};
    v[6] = '{k:4, bt:78, sp:-1, hold:0, done:78, rt:15, fs:0, to:1};
    repeat (2) @(posedge clk);
    #1 chk("reset outs", outs(), 0);
    rst_n = 1'b1;
    foreach (v[i]) begin
      run_game(v[i].k, v[i].bt, v[i].sp, v[i].hold, d, r, f, o);
      chk($sformatf("vec%0d done", i), d, v[i].done);
      chk($sformatf("vec%0d rt", i), r, v[i].rt);
      chk($sformatf("vec%0d fs", i), f, v[i].fs);
      chk($sformatf("vec%0d to", i), o, v[i].to);
    end
    reset_mid(3, 36);
    run_game(2, 45, -1, 0, d, r, f, o);
    chk("clean after reset rt", r, 2);
    for (int g = 0; g < 25; g++) begin
      k = $urandom_range(0, 5);
      tm = meas_start(k);
      mode = $urandom_range(0, 4);
      if (mode == 4) reset_mid(k, $urandom_range(0, tm + 20));
      else begin
        bt = (mode == 0) ? $urandom_range(0, tm - 1) : (mode == 3) ? -1 : tm + $urandom_range(0, 33);
        sp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
        run_game(k, bt, sp, 1'($urandom_range(0, 1)), d, r, f, o);
        chk($sformatf("rand%0d done", g), d, done_at(k, bt));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
